// File: rtl/alu_div_unit.sv
// Signed WIDTH-bit divider using a non-restoring loop that produces one quotient bit per cycle. Optional DIV_REMAINDER_EN adds data_remainder.
// Latency: result-ready is high in the cycle after edge WIDTH+2 counted from the accepting edge. For divide-by-zero it is high after edge 1.
// Backpressure: busy is high in RUN and SIGN. ctrl_DIV is ignored while busy; there is no queueing and the operands are not resampled.
module alu_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             busy
);

    localparam int              CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH:0]  ONE_X = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;      // signed partial remainder
    logic [WIDTH:0]   div_q;      // |B|, one extra bit so |-2^(W-1)| is exact
    logic [WIDTH-1:0] quo_q;      // holds |A| at first, then quotient bits shift in
    logic             qneg_q;     // quotient sign: sign(A) ^ sign(B)
    logic             ovf_q;      // MIN / -1 overflow detected at start

    logic             accept, b_zero;
    logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
    logic [WIDTH:0]   shifted, stepped;
    logic [WIDTH-1:0] quo_signed;

    // Operand magnitudes and one non-restoring step
    always_comb begin
        accept     = ctrl_DIV && ((state_q == IDLE) || (state_q == DONE));
        b_zero     = (data_operandB == '0);
        a_ext      = {data_operandA[WIDTH-1], data_operandA};
        b_ext      = {data_operandB[WIDTH-1], data_operandB};
        a_mag      = a_ext[WIDTH] ? (~a_ext + ONE_X) : a_ext;
        b_mag      = b_ext[WIDTH] ? (~b_ext + ONE_X) : b_ext;
        shifted    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        stepped    = rem_q[WIDTH] ? (shifted + div_q) : (shifted - div_q);
        quo_signed = qneg_q ? (~quo_q + ONE_W) : quo_q;
    end

`ifdef DIV_REMAINDER_EN
    logic             rneg_q;     // remainder follows the dividend's sign
    logic [WIDTH:0]   rem_fix;
    logic [WIDTH-1:0] rem_signed;

    // Restore the final remainder if it went negative, then apply the sign
    always_comb begin
        rem_fix    = rem_q[WIDTH] ? (rem_q + div_q) : rem_q;
        rem_signed = rneg_q ? (~rem_fix[WIDTH-1:0] + ONE_W) : rem_fix[WIDTH-1:0];
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, a_mag[WIDTH], rem_fix[WIDTH]};
`else
    logic unused_bits;
    assign unused_bits = &{1'b0, a_mag[WIDTH]};
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, busy and result-ready decode
    always_comb begin
        state_d        = state_q;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                data_resultRDY = (state_q == DONE);
                if (ctrl_DIV) state_d = b_zero ? DONE : RUN;
                else          state_d = IDLE;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST) state_d = SIGN;
            end
            SIGN: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in RUN, sign-fix and publish in SIGN
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q          <= '0;
            rem_q          <= '0;
            div_q          <= '0;
            quo_q          <= '0;
            qneg_q         <= 1'b0;
            ovf_q          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rneg_q         <= 1'b0;
            data_remainder <= '0;
`endif
        end else if (accept) begin
            cnt_q          <= '0;
            rem_q          <= '0;
            div_q          <= b_mag;
            quo_q          <= a_mag[WIDTH-1:0];
            qneg_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ovf_q          <= (data_operandA == MIN_W) && (data_operandB == '1);
            data_exception <= b_zero;
`ifdef DIV_REMAINDER_EN
            rneg_q         <= data_operandA[WIDTH-1];
`endif
            if (b_zero) begin
                data_result    <= '0;
`ifdef DIV_REMAINDER_EN
                data_remainder <= '0;
`endif
            end
        end else if (state_q == RUN) begin
            rem_q <= stepped;
            quo_q <= {quo_q[WIDTH-2:0], ~stepped[WIDTH]};
            cnt_q <= cnt_q + 1'b1;
        end else if (state_q == SIGN) begin
            data_result    <= quo_signed;
            data_exception <= ovf_q;
`ifdef DIV_REMAINDER_EN
            data_remainder <= rem_signed;
`endif
        end
    end

endmodule

// File: tb/tb_alu_div_unit.sv
module tb_alu_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int total = 0;
    int bad   = 0;

    alu_div_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] a, b, q, r;
        logic        e;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
        longint sa, sb, qq, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = 32'h0; r = 32'h0; e = 1'b1;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[31:0];
            r  = rr[31:0];
            e  = (qq > 64'sd2147483647);
        end
    endtask

    // Counts edges from 'start' until result-ready is seen, with a bound
    task automatic wait_rdy(input int start, output int lat);
        lat = start;
        while (!data_resultRDY && lat < 200) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic e,
                         input int lat_exp);
        int lat;
        int busy_err;
        busy_err = 0;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat = 1;
        while (!data_resultRDY && lat < 200) begin
            if (busy !== (b != 0)) busy_err++;
            @(negedge clock);
            lat++;
        end
        if (busy !== 1'b0) busy_err++;
        chk({name, " latency"}, 64'(lat), 64'(lat_exp));
        chk({name, " result"}, {32'h0, data_result}, {32'h0, q});
        chk({name, " exception"}, {63'h0, data_exception}, {63'h0, e});
`ifdef DIV_REMAINDER_EN
        chk({name, " remainder"}, {32'h0, data_remainder}, {32'h0, r});
`else
        if (r === 32'hx) busy_err++;
`endif
        chk({name, " busy"}, 64'(busy_err), 64'h0);
        @(negedge clock);
        chk({name, " rdy pulse"}, {63'h0, data_resultRDY}, 64'h0);
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] ra, rb, mq, mr;
        logic        me;
        int          lat, rdy_cnt;

        vecs[0] = '{"pos_pos",  32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34};
        vecs[1] = '{"neg_pos",  32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34};
        vecs[2] = '{"pos_neg",  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 34};
        vecs[3] = '{"divzero",  32'd5,        32'd0,        32'd0,        32'd0,        1'b1, 1};
        vecs[4] = '{"overflow", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b1, 34};
        vecs[5] = '{"max_by1",  32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, 34};
        vecs[6] = '{"small",    32'd3,        32'd4,        32'd0,        32'd3,        1'b0, 34};
        vecs[7] = '{"m1_bymin", 32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0, 34};

        reset = 1'b1; ctrl_DIV = 1'b1; data_operandA = 32'd9; data_operandB = 32'd0;
        repeat (2) @(negedge clock);
        chk("reset result", {32'h0, data_result}, 64'h0);
        chk("reset exc", {63'h0, data_exception}, 64'h0);
        chk("reset rdy", {63'h0, data_resultRDY}, 64'h0);
        chk("reset busy", {63'h0, busy}, 64'h0);
        reset = 1'b0; ctrl_DIV = 1'b0;

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e, vecs[i].lat);

        // Start ignored while busy, then back-to-back restart from DONE
        @(negedge clock);
        data_operandA = 32'd1000; data_operandB = 32'd10; ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0; data_operandA = $urandom;
        repeat (3) @(negedge clock);
        data_operandA = 32'd9; data_operandB = 32'd3; ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_rdy(5, lat);
        chk("ignore latency", 64'(lat), 64'd34);
        chk("ignore result", {32'h0, data_result}, 64'd100);
        data_operandA = 32'd9; data_operandB = 32'd3; ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        chk("b2b rdy dropped", {63'h0, data_resultRDY}, 64'h0);
        chk("b2b busy", {63'h0, busy}, 64'h1);
        wait_rdy(1, lat);
        chk("b2b latency", 64'(lat), 64'd34);
        chk("b2b result", {32'h0, data_result}, 64'd3);
        chk("b2b exc", {63'h0, data_exception}, 64'h0);

        // Reset mid-operation aborts
        @(negedge clock);
        data_operandA = 32'd50; data_operandB = 32'd5; ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort result", {32'h0, data_result}, 64'h0);
        chk("abort busy", {63'h0, busy}, 64'h0);
        chk("abort rdy", {63'h0, data_resultRDY}, 64'h0);
`ifdef DIV_REMAINDER_EN
        chk("abort rem", {32'h0, data_remainder}, 64'h0);
`endif
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (data_resultRDY) rdy_cnt++;
            @(negedge clock);
        end
        chk("abort no rdy", 64'(rdy_cnt), 64'h0);
        do_op("after_abort", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34);

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(0, 30)) - 32'd15;
                2: begin ra = 32'h80000000; rb = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'd1; end
                3: rb = $urandom >> $urandom_range(0, 31);
                default: begin ra = 32'($urandom_range(0, 1000)) - 32'd500; rb = 32'($urandom_range(1, 40)); end
            endcase
            model(ra, rb, mq, mr, me);
            do_op("random", ra, rb, mq, mr, me, (rb == 0) ? 1 : 34);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
